// File: rtl/mipi_phy_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mipi_phy_ser_ctrl
// Purpose  : D-PHY data-lane transmit sequencer (LP-11 -> SoT -> HS payload ->
//            trailer -> LP-11). Optional macro MIPI_TX_BYTECOUNT_EN adds
//            byte_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module mipi_phy_ser_ctrl #(
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 4,
    parameter int T_HS_ZERO    = 8,
    parameter int T_HS_TRAIL   = 4,
    parameter int T_HS_EXIT    = 8
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    input  logic       md_polarity_i,
    output logic [7:0] hs_data_o,
    output logic       hs_oe_o,
    output logic       lp_p_o,
    output logic       lp_n_o,
    output logic       busy_o,
    output logic       underrun_o
`ifdef MIPI_TX_BYTECOUNT_EN
    ,
    output logic [15:0] byte_count_o
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LP01   = 3'd1;
    localparam logic [2:0] S_LP00   = 3'd2;
    localparam logic [2:0] S_HSZERO = 3'd3;
    localparam logic [2:0] S_SYNC   = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_TRAIL  = 3'd6;
    localparam logic [2:0] S_EXIT   = 3'd7;

    // Counter reload values: a state of N cycles loads N-1; zero is treated as one.
    localparam logic [7:0] LD_LPX   = (T_LPX        <= 1) ? 8'd0 : 8'(T_LPX - 1);
    localparam logic [7:0] LD_PREP  = (T_HS_PREPARE <= 1) ? 8'd0 : 8'(T_HS_PREPARE - 1);
    localparam logic [7:0] LD_ZERO  = (T_HS_ZERO    <= 1) ? 8'd0 : 8'(T_HS_ZERO - 1);
    localparam logic [7:0] LD_TRAIL = (T_HS_TRAIL   <= 1) ? 8'd0 : 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] LD_EXIT  = (T_HS_EXIT    <= 1) ? 8'd0 : 8'(T_HS_EXIT - 1);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hs_data_q, hs_data_d;
    logic [7:0] byte_d;
    logic       hs_oe_q, hs_oe_d;
    logic       lp_p_q, lp_p_d;
    logic       lp_n_q, lp_n_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       underrun_q, underrun_d;
    logic       refbit_q, refbit_d;
    logic [7:0] trail_byte;

    // Assertion is immediate through the async clear; release waits two clocks.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign trail_byte = refbit_q ? 8'h00 : 8'hFF;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
        byte_d     = 8'h00;
        hs_oe_d    = hs_oe_q;
        lp_p_d     = lp_p_q;
        lp_n_d     = lp_n_q;
        ready_d    = 1'b0;
        underrun_d = 1'b0;
        refbit_d   = refbit_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid_i) begin
                    state_d = S_LP01;
                    cnt_d   = LD_LPX;
                    lp_p_d  = 1'b0;
                    lp_n_d  = 1'b1;
                end
            end
            S_LP01: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_LP00;
                    cnt_d   = LD_PREP;
                    lp_n_d  = 1'b0;
                end
            end
            S_LP00: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HSZERO;
                    cnt_d   = LD_ZERO;
                    hs_oe_d = 1'b1;
                end
            end
            S_HSZERO: begin
                if (cnt_q == 8'd0) begin
                    state_d  = S_SYNC;
                    byte_d   = 8'hB8;
                    ready_d  = 1'b1;
                    refbit_d = 1'b1;
                end
            end
            S_SYNC, S_DATA: begin
                if (ready_q && tx_valid_i) begin
                    state_d  = S_DATA;
                    byte_d   = tx_data_i;
                    refbit_d = tx_data_i[7];
                    ready_d  = !tx_last_i;
                end else begin
                    // Either the final byte has just been output or upstream starved us.
                    state_d    = S_TRAIL;
                    cnt_d      = LD_TRAIL;
                    byte_d     = trail_byte;
                    underrun_d = ready_q;
                end
            end
            S_TRAIL: begin
                byte_d = trail_byte;
                if (cnt_q == 8'd0) begin
                    state_d = S_EXIT;
                    cnt_d   = LD_EXIT;
                    byte_d  = 8'h00;
                    hs_oe_d = 1'b0;
                    lp_p_d  = 1'b1;
                    lp_n_d  = 1'b1;
                end
            end
            S_EXIT: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                hs_oe_d = 1'b0;
                lp_p_d  = 1'b1;
                lp_n_d  = 1'b1;
            end
        endcase
        busy_d    = (state_d != S_IDLE);
        hs_data_d = hs_oe_d ? (byte_d ^ {8{md_polarity_i}}) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            hs_data_q  <= 8'h00;
            hs_oe_q    <= 1'b0;
            lp_p_q     <= 1'b1;
            lp_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            refbit_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hs_data_q  <= hs_data_d;
            hs_oe_q    <= hs_oe_d;
            lp_p_q     <= lp_p_d;
            lp_n_q     <= lp_n_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            refbit_q   <= refbit_d;
        end
    end

    assign tx_ready_o = ready_q;
    assign hs_data_o  = hs_data_q;
    assign hs_oe_o    = hs_oe_q;
    assign lp_p_o     = lp_p_q;
    assign lp_n_o     = lp_n_q;
    assign busy_o     = busy_q;
    assign underrun_o = underrun_q;

`ifdef MIPI_TX_BYTECOUNT_EN
    logic [15:0] bc_q, bc_d;

    always_comb begin
        bc_d = bc_q;
        if (state_q == S_IDLE && state_d == S_LP01)
            bc_d = 16'd0;
        else if (ready_q && tx_valid_i && bc_q != 16'hFFFF)
            bc_d = bc_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bc_q <= 16'd0;
        else        bc_q <= bc_d;
    end

    assign byte_count_o = bc_q;
`endif

endmodule
`default_nettype wire
